// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: 5-stage pipe hazard/forwarding/flush/stall control with memory watchdog; PIPELINE_PERF_CNT_EN adds stall_cycles/flush_events counters
module pipeline_hazard_ctrl #(
  parameter int RAW = 5,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [RAW-1:0]   id_rs1,
  input  logic [RAW-1:0]   id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [RAW-1:0]   ex_rs1,
  input  logic [RAW-1:0]   ex_rs2,
  input  logic [RAW-1:0]   ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic [RAW-1:0]   mem_rd,
  input  logic             mem_reg_write,
  input  logic [RAW-1:0]   wb_rd,
  input  logic             wb_reg_write,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             flush_memwb,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);
  typedef enum logic [1:0] {INIT, RUN, MEM_WAIT, ERROR} state_t;
  localparam int WW = MEM_TIMEOUT > 0 ? $clog2(MEM_TIMEOUT + 1) : 1;
  state_t state;
  logic [WW-1:0] wcnt;
  logic load_use, freeze, trip;
  logic [3:0] en;
  logic [2:0] fl;
  assign load_use = ex_mem_read && ex_rd != '0 &&
                    ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
  assign freeze = state == MEM_WAIT ? !mem_ready : state == RUN && mem_req && !mem_ready;
  assign trip = MEM_TIMEOUT != 0 && wcnt == WW'(MEM_TIMEOUT - 1);
  always_comb
    {en, fl} = !reset || state == INIT ? 7'b0000_111
             : state == ERROR          ? 7'b0000_000
             : freeze                  ? 7'b0000_001
             : ex_branch_taken         ? 7'b1111_110
             : load_use                ? 7'b0011_010
             :                           7'b1111_000;
  assign {pc_en, ifid_en, idex_en, exmem_en} = en;
  assign {flush_ifid, flush_idex, flush_memwb} = fl;
  assign fwd_a = !reset ? 2'b00
               : mem_reg_write && mem_rd != '0 && mem_rd == ex_rs1 ? 2'b10
               : wb_reg_write && wb_rd != '0 && wb_rd == ex_rs1   ? 2'b01 : 2'b00;
  assign fwd_b = !reset ? 2'b00
               : mem_reg_write && mem_rd != '0 && mem_rd == ex_rs2 ? 2'b10
               : wb_reg_write && wb_rd != '0 && wb_rd == ex_rs2   ? 2'b01 : 2'b00;
  assign mem_timeout = state == ERROR;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= INIT;
      wcnt  <= '0;
    end else begin
      state <= state == INIT     ? RUN
             : state == RUN      ? (freeze ? MEM_WAIT : RUN)
             : state == MEM_WAIT ? (mem_ready ? RUN : trip ? ERROR : MEM_WAIT)
             :                     ERROR;
      wcnt  <= state == MEM_WAIT && !mem_ready ? wcnt + 1'b1 : '0;
    end
`ifdef PIPELINE_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else if (state != INIT) begin
      if (!pc_en && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
      if (flush_ifid && flush_events != '1) flush_events <= flush_events + 1'b1;
    end
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed stimulus with a per-cycle reference model of pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;
  localparam int MEM_TIMEOUT = 16;
`ifdef PIPELINE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken;
  logic mem_reg_write, wb_reg_write, mem_req, mem_ready;
  logic pc_en, ifid_en, idex_en, exmem_en, flush_ifid, flush_idex, flush_memwb, mem_timeout;
  logic [1:0] fwd_a, fwd_b;
  logic [31:0] stall_cycles, flush_events;
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  pipeline_hazard_ctrl #(.RAW(5), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex), .flush_memwb(flush_memwb),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask
  function automatic logic [1:0] fsel(input logic [4:0] rs);
    if (mem_reg_write && mem_rd != 0 && mem_rd == rs) return 2'b10;
    if (wb_reg_write && wb_rd != 0 && wb_rd == rs) return 2'b01;
    return 2'b00;
  endfunction
  bit booted = 0, dead = 0, stalled, lu;
  int waits = 0;
  logic [31:0] cs = 0, cf = 0;
  logic [3:0] xen;
  logic [2:0] xfl;
  logic [1:0] xa, xb;
  always @(negedge clk) begin
    stalled = 0;
    lu = ex_mem_read && ex_rd != 0 && ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    if (!reset || !booted) begin
      xen = 4'b0000; xfl = 3'b111;
    end else if (dead) begin
      xen = 4'b0000; xfl = 3'b000;
    end else begin
      stalled = waits > 0 ? !mem_ready : (mem_req && !mem_ready);
      if (stalled) begin xen = 4'b0000; xfl = 3'b001; end
      else if (ex_branch_taken) begin xen = 4'b1111; xfl = 3'b110; end
      else if (lu) begin xen = 4'b0011; xfl = 3'b010; end
      else begin xen = 4'b1111; xfl = 3'b000; end
    end
    xa = reset ? fsel(ex_rs1) : 2'b00;
    xb = reset ? fsel(ex_rs2) : 2'b00;
    chk("model enables", {pc_en, ifid_en, idex_en, exmem_en}, xen);
    chk("model flushes", {flush_ifid, flush_idex, flush_memwb}, xfl);
    chk("model fwd", {fwd_a, fwd_b}, {xa, xb});
    chk("model mem_timeout", mem_timeout, reset && booted && dead);
    chk("model stall_cycles", stall_cycles, reset ? cs : 32'd0);
    chk("model flush_events", flush_events, reset ? cf : 32'd0);
    if (!reset) begin
      booted = 0; dead = 0; waits = 0; cs = 0; cf = 0;
    end else if (!booted) begin
      booted = 1;
    end else begin
      if (PERF && !xen[3] && cs != '1) cs = cs + 1;
      if (PERF && xfl[2] && cf != '1) cf = cf + 1;
      if (!dead) begin
        waits = stalled ? waits + 1 : 0;
        if (MEM_TIMEOUT != 0 && waits > MEM_TIMEOUT) dead = 1;
      end
    end
  end
  task automatic idle();
    {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
    {id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken} = '0;
    {mem_reg_write, wb_reg_write, mem_req, mem_ready} = '0;
  endtask
  task automatic settle();
    @(negedge clk);
  endtask
  task automatic adv();
    @(posedge clk);
    #1;
  endtask
  task automatic set_lu();
    ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1;
  endtask
  logic [31:0] snap;
  initial begin
    idle();
    settle();
    chk("reset enables", {pc_en, ifid_en, idex_en, exmem_en}, 4'b0000);
    chk("reset flushes", {flush_ifid, flush_idex, flush_memwb}, 3'b111);
    adv(); adv();
    reset = 1;
    settle();
    chk("init enables", {pc_en, ifid_en, idex_en, exmem_en}, 4'b0000);
    chk("init flushes", {flush_ifid, flush_idex, flush_memwb}, 3'b111);
    adv();
    settle();
    chk("run enables", {pc_en, ifid_en, idex_en, exmem_en}, 4'b1111);
    chk("run flushes", {flush_ifid, flush_idex, flush_memwb}, 3'b000);
    adv();
    set_lu();
    settle();
    chk("load-use enables", {pc_en, ifid_en, idex_en, exmem_en}, 4'b0011);
    chk("load-use flushes", {flush_ifid, flush_idex, flush_memwb}, 3'b010);
    adv();
    idle();
    settle();
    chk("after load-use pc_en", pc_en, 1'b1);
    adv();
    ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; id_uses_rs1 = 1;
    settle();
    chk("load rd0 pc_en", pc_en, 1'b1);
    adv();
    idle(); set_lu(); ex_branch_taken = 1;
    settle();
    chk("branch flushes", {flush_ifid, flush_idex, flush_memwb}, 3'b110);
    chk("branch pc_en", pc_en, 1'b1);
    snap = flush_events;
    adv();
    idle();
    settle();
    chk("branch flush_events delta", flush_events - snap, PERF ? 32'd1 : 32'd0);
    adv();
    ex_rs1 = 3; mem_rd = 3; wb_rd = 3; mem_reg_write = 1; wb_reg_write = 1; ex_rs2 = 0;
    settle();
    chk("fwd_a mem", fwd_a, 2'b10);
    chk("fwd_b rs2=0", fwd_b, 2'b00);
    adv();
    mem_reg_write = 0; ex_rs2 = 3;
    settle();
    chk("fwd_a wb", fwd_a, 2'b01);
    chk("fwd_b wb", fwd_b, 2'b01);
    adv();
    idle(); mem_req = 1; ex_branch_taken = 1;
    for (int i = 0; i < 4; i++) begin
      settle();
      if (i == 0) snap = stall_cycles;
      chk("mem wait enables", {pc_en, ifid_en, idex_en, exmem_en}, 4'b0000);
      chk("mem wait flush_memwb", flush_memwb, 1'b1);
      adv();
    end
    mem_ready = 1;
    settle();
    chk("mem release enables", {pc_en, ifid_en, idex_en, exmem_en}, 4'b1111);
    chk("mem release flushes", {flush_ifid, flush_idex, flush_memwb}, 3'b110);
    adv();
    idle();
    settle();
    chk("mem wait stall delta", stall_cycles - snap, PERF ? 32'd4 : 32'd0);
    adv();
    mem_req = 1; mem_ready = 1;
    settle();
    chk("ready same cycle pc_en", pc_en, 1'b1);
    adv();
    idle(); mem_req = 1; set_lu();
    settle();
    chk("wait over load-use flushes", {flush_ifid, flush_idex, flush_memwb}, 3'b001);
    adv();
    mem_ready = 1;
    settle();
    chk("load-use after wait enables", {pc_en, ifid_en, idex_en, exmem_en}, 4'b0011);
    adv();
    idle(); mem_req = 1;
    for (int i = 0; i < 16; i++) begin
      settle();
      chk("pre-boundary mem_timeout", mem_timeout, 1'b0);
      adv();
    end
    mem_ready = 1;
    settle();
    chk("ready at boundary pc_en", pc_en, 1'b1);
    adv();
    idle();
    settle();
    chk("ready at boundary mem_timeout", mem_timeout, 1'b0);
    adv();
    mem_req = 1;
    for (int i = 0; i < 17; i++) begin
      settle();
      chk("watchdog pending", {mem_timeout, pc_en}, 2'b00);
      adv();
    end
    settle();
    chk("watchdog mem_timeout", mem_timeout, 1'b1);
    chk("error flushes", {flush_ifid, flush_idex, flush_memwb}, 3'b000);
    adv();
    mem_ready = 1; ex_rs1 = 3; mem_rd = 3; mem_reg_write = 1;
    settle();
    chk("error sticky", {mem_timeout, pc_en}, 2'b10);
    chk("error fwd_a", fwd_a, 2'b10);
    #2 reset = 0;
    #1;
    chk("async reset mem_timeout", mem_timeout, 1'b0);
    chk("async reset fwd_a", fwd_a, 2'b00);
    chk("async reset flushes", {flush_ifid, flush_idex, flush_memwb}, 3'b111);
    chk("async reset stall_cycles", stall_cycles, 32'd0);
    adv(); adv();
    idle();
    reset = 1;
    settle();
    chk("re-init pc_en", pc_en, 1'b0);
    adv();
    settle();
    chk("re-run enables", {pc_en, ifid_en, idex_en, exmem_en}, 4'b1111);
    adv();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
